mac_neuron_acc: RTL
===================

// Module: mac_neuron_acc
// PURPOSE
//  Sequential neuron MAC: accepts a stream of N_INPUTS (pixel, weight) pairs and
//  accumulates their products onto a bias in a wide accumulator. It then applies a
//  fixed-point rescale, optional ReLU and saturation, and returns one activation per job.
//  Sits between the layer's pixel/weight memories and the activation write-back.
//  Replaces one-product-per-cycle MAC use with a self-counting, back-pressured accumulator.
// PARAMETERS
//  DATA_W     16   signed two's-complement width of pixel and weight
//  N_INPUTS   784  pairs per job (>=1)
//  ACC_W      48   accumulator width; must be >= 2*DATA_W+$clog2(N_INPUTS)+1
//  FRAC_BITS  8    fractional bits of pixel/weight; output = acc >>> FRAC_BITS
//  OUT_W      32   signed output width
//  RELU_EN    1    1: negative results forced to 0
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         async active-high reset
//  start      in   1         begin job; sampled only in IDLE
//  bias_in    in   2*DATA_W  signed bias in product scale (2*FRAC_BITS frac bits), latched on start
//  in_valid   in   1         pair valid
//  in_ready   out  1         pair accepted when in_valid&in_ready
//  pixel_in   in   DATA_W    signed pixel
//  weights_in in   DATA_W    signed weight
//  out_valid  out  1         result valid, held until out_ready
//  out_ready  in   1         consumer accepts result
//  out        out  OUT_W     signed activation
//  busy       out  1         high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid and busy =0; out=0; acc, count and pipeline valids =0.
//  FSM:
//   IDLE   --start--> ACCUM. acc <= sext(bias_in), count <= 0.
//   ACCUM  in_ready=1. Each handshake increments count.
//          Handshake with count==N_INPUTS-1 -> DRAIN.
//   DRAIN  in_ready=0. Wait until both pipeline valids clear, then register result -> DONE.
//   DONE   out_valid=1 and out stable. out_ready=1 -> IDLE with out_valid=0.
//  Pipeline:
//   S1 registers pair + valid.
//   S2 registers signed product (2*DATA_W) + valid.
//   S3 acc += sext(product) when S2 valid.
//   Bubbles from in_valid=0 propagate as invalid; acc is untouched by them.
//  Latency: out_valid rises on the 4th rising edge after the edge that accepted the last pair.
//  Output stage (combinational from acc, registered into out):
//   r = acc >>> FRAC_BITS (arithmetic); if RELU_EN and r<0 then r=0.
//   Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  Accumulator never saturates internally; ACC_W sizing guarantees no wrap.
//  Boundaries:
//   start outside IDLE: ignored. bias_in is sampled only on an accepted start.
//   out_ready together with start in DONE: start ignored. It must be re-presented in IDLE.
//   N_INPUTS=1: a single handshake moves ACCUM->DRAIN.
//   in_valid while in_ready=0: no effect.
//   rst mid-job: immediate abort to IDLE, partial acc discarded, no out_valid.
// STRUCTURE
//  Shared package nn_mac_pkg: FSM state encodings (IDLE/ACCUM/DRAIN/DONE, 2-bit)
//   and sat/ReLU width helper constants.
//  Sub-module mac_out_sat: acc -> shift, ReLU, clamp. Combinational, parametrised by
//   ACC_W/FRAC_BITS/OUT_W/RELU_EN, reused by later layers.
//  Top holds the FSM, counter, S1/S2 registers and accumulator.
// TESTING (bench params N_INPUTS=4, FRAC_BITS=8, DATA_W=16 unless stated)
//  1 Reset:
//     rst pulse mid-idle -> out=0, out_valid=0, in_ready=0, busy=0.
//  2 Basic job:
//     bias_in=32768; 4 pairs of pixel=256, weight=512, back-to-back -> out=2176,
//     out_valid exactly 4 edges after last handshake.
//  3 ReLU:
//     as test 2 with weight=-512 -> RELU_EN=1: out=0; RELU_EN=0: out=-1920.
//  4 Saturation (OUT_W=16, bias 0):
//     4x(32767*32767) -> out=32767.
//     4x(32767*-32768) with RELU_EN=0 -> out=-32768.
//  5 Stalls:
//     test 2 with in_valid toggling every cycle, out_ready low 5 cycles after out_valid,
//     start pulsed in ACCUM and DONE -> out=2176 held stable, one result only, starts ignored.
//  6 Abort:
//     rst asserted after 2 handshakes, then a full test-2 job -> out=2176, no stale result.

Source files
------------

// File: rtl/nn_mac_pkg.sv
// Shared FSM encodings and sizing helpers for the neuron MAC datapath.
package nn_mac_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ACCUM = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sign/guard bits above the OUT_W-1 magnitude bits of a clamp bound.
  function automatic int sat_pad(input int acc_w, input int out_w);
    return acc_w - out_w + 1;
  endfunction

endpackage

// File: rtl/mac_out_sat.sv
// Accumulator to activation: arithmetic rescale, optional ReLU, clamp.
module mac_out_sat
  import nn_mac_pkg::*;
#(
  parameter int ACC_W     = 48,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 32,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] res
);

  localparam int PAD = sat_pad(ACC_W, OUT_W);

  localparam logic [ACC_W-1:0] MAXV =
    {{PAD{1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MINV =
    {{PAD{1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r;

  always_comb begin
    r = $signed(acc) >>> FRAC_BITS;
    if (RELU_EN && r[ACC_W-1]) r = '0;
    if (r > $signed(MAXV))
      res = MAXV[OUT_W-1:0];
    else if (r < $signed(MINV))
      res = MINV[OUT_W-1:0];
    else
      res = r[OUT_W-1:0];
  end

endmodule

// File: rtl/mac_neuron_acc.sv
// Self-counting, back-pressured neuron MAC: bias + sum(pixel*weight),
// then rescale/ReLU/saturate into one registered activation per job.
module mac_neuron_acc
  import nn_mac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int N_INPUTS  = 784,
  parameter int ACC_W     = 48,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 32,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*DATA_W-1:0] bias_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   pixel_in,
  input  logic [DATA_W-1:0]   weights_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out,
  output logic                busy
);

  localparam int CW = cnt_w(N_INPUTS);
  localparam int PW = 2 * DATA_W;

  logic [ST_W-1:0] state;
  logic [CW-1:0]   count;

  logic                     s1_v;
  logic                     s2_v;
  logic                     s3_v;
  logic signed [DATA_W-1:0] s1_pix;
  logic signed [DATA_W-1:0] s1_wt;
  logic signed [PW-1:0]     s2_prod;
  logic [ACC_W-1:0]         acc;
  logic [OUT_W-1:0]         res;
  logic [OUT_W-1:0]         out_q;

  logic hs;
  logic last;
  logic drained;

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out       = out_q;

  assign hs      = in_valid & in_ready;
  assign last    = (count == CW'(N_INPUTS - 1));
  // s3_v marks the cycle the last add lands, so the clamp sees a settled acc.
  assign drained = !(s1_v | s2_v | s3_v);

  mac_out_sat #(
    .ACC_W    (ACC_W),
    .FRAC_BITS(FRAC_BITS),
    .OUT_W    (OUT_W),
    .RELU_EN  (RELU_EN)
  ) u_sat (
    .acc(acc),
    .res(res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s3_v    <= 1'b0;
      s1_pix  <= '0;
      s1_wt   <= '0;
      s2_prod <= '0;
      acc     <= '0;
      out_q   <= '0;
    end else begin
      s1_v <= hs;
      if (hs) begin
        s1_pix <= $signed(pixel_in);
        s1_wt  <= $signed(weights_in);
      end
      s2_v <= s1_v;
      if (s1_v) s2_prod <= s1_pix * s1_wt;
      s3_v <= s2_v;
      if (s2_v)
        acc <= acc + {{(ACC_W-PW){s2_prod[PW-1]}}, s2_prod};

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= {{(ACC_W-PW){bias_in[PW-1]}}, bias_in};
            count <= '0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (hs) begin
            count <= count + CW'(1);
            if (last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            out_q <= res;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
